// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with three registered read ports, one write port and a
// per-register busy scoreboard. Decode reserves a destination with RSV_EN;
// writeback (RD_LE) clears the reservation. A reserve and a clear of the same
// register on the same edge leave it busy, because the reservation belongs to
// the younger instruction.
module lc3_regfile_sb #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int WRITE_FIRST = 1
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   RD_LE,
    input  logic [ADDR_W-1:0]      RD,
    input  logic [DATA_W-1:0]      DATA_IN,
    input  logic [ADDR_W-1:0]      RS1,
    input  logic [ADDR_W-1:0]      RS2,
    input  logic                   RSV_EN,
    input  logic [ADDR_W-1:0]      RSV_ADDR,
    output logic [DATA_W-1:0]      RS1_DATA,
    output logic [DATA_W-1:0]      RS2_DATA,
    output logic [DATA_W-1:0]      RD_DATA,
    output logic                   RS1_BUSY,
    output logic                   RS2_BUSY,
    output logic [2**ADDR_W-1:0]   BUSY_VEC
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DATA_W-1:0] rs1_d;
    logic [DATA_W-1:0] rs2_d;
    logic [DATA_W-1:0] rd_d;
    logic              rs1_busy_d;
    logic              rs2_busy_d;

    // Next scoreboard state: clear on writeback, then a reservation overrides it.
    always_comb begin
        busy_d = busy_q;
        if (RD_LE) begin
            busy_d[RD] = 1'b0;
        end
        if (RSV_EN) begin
            busy_d[RSV_ADDR] = 1'b1;
        end
    end

    // Read-port muxes; in write-first mode a same-edge write bypasses the array.
    always_comb begin
        rs1_d = regs[RS1];
        rs2_d = regs[RS2];
        rd_d  = regs[RD];
        if (WRITE_FIRST != 0 && RD_LE) begin
            if (RS1 == RD) begin
                rs1_d = DATA_IN;
            end
            if (RS2 == RD) begin
                rs2_d = DATA_IN;
            end
            rd_d = DATA_IN;
        end
        rs1_busy_d = (WRITE_FIRST != 0) ? busy_d[RS1] : busy_q[RS1];
        rs2_busy_d = (WRITE_FIRST != 0) ? busy_d[RS2] : busy_q[RS2];
    end

    // Register array, scoreboard and registered read outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q   <= '0;
            RS1_DATA <= '0;
            RS2_DATA <= '0;
            RD_DATA  <= '0;
            RS1_BUSY <= 1'b0;
            RS2_BUSY <= 1'b0;
        end else begin
            if (RD_LE) begin
                regs[RD] <= DATA_IN;
            end
            busy_q   <= busy_d;
            RS1_DATA <= rs1_d;
            RS2_DATA <= rs2_d;
            RD_DATA  <= rd_d;
            RS1_BUSY <= rs1_busy_d;
            RS2_BUSY <= rs2_busy_d;
        end
    end

    assign BUSY_VEC = busy_q;

endmodule

// File: doc/lc3_regfile_sb.md
Name: lc3_regfile_sb

Overview:
- Parametrised successor to the LC-3 eight-entry register file.
- Three registered read ports (RS1, RS2, RD), one write port, and a per-register busy scoreboard.
- The decode/issue stage reserves a destination register, and writeback clears the reservation.
- Sits between decode (read addresses, reservations) and writeback (DATA_IN, RD_LE) in the LC3 datapath.

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers (default 8, R0..R7).
- WRITE_FIRST, 1: 1 = a read of the register written on the same edge returns the new data; 0 = returns the old data.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- RD_LE, input, 1: write enable for register RD.
- RD, input, ADDR_W: write address and RD read-port address.
- DATA_IN, input, DATA_W: write data.
- RS1, input, ADDR_W: read-port-1 address.
- RS2, input, ADDR_W: read-port-2 address.
- RSV_EN, input, 1: reserve request; marks RSV_ADDR busy.
- RSV_ADDR, input, ADDR_W: register to reserve.
- RS1_DATA, output, DATA_W: registered contents of RS1.
- RS2_DATA, output, DATA_W: registered contents of RS2.
- RD_DATA, output, DATA_W: registered contents of RD.
- RS1_BUSY, output, 1: registered busy bit of RS1.
- RS2_BUSY, output, 1: registered busy bit of RS2.
- BUSY_VEC, output, DEPTH: live scoreboard; bit i = register i busy.

Behaviour:
- Reset
  - RESET_N low asynchronously clears all DEPTH registers, every data output, RS1_BUSY, RS2_BUSY and BUSY_VEC to 0.
  - This holds regardless of CLK.
  - The first update is on the first rising CLK with RESET_N high.
  - Reset mid-operation drops any pending write and all reservations.
- Write
  - On a rising edge with RD_LE=1, reg[RD] <= DATA_IN. RD_LE=0 leaves all registers unchanged.
- Read latency
  - 1 cycle. Addresses sampled at edge N appear on the *_DATA and *_BUSY outputs after edge N.
  - Outputs hold between edges; no combinational path from address to output.
- Same-edge write and read (any port's address == RD with RD_LE=1)
  - WRITE_FIRST=1: output = DATA_IN.
  - WRITE_FIRST=0: output = previous contents.
  - RD_DATA follows the same rule.
- All three read ports are independent. Identical addresses on several ports return identical data.
- Scoreboard, per bit i, evaluated each edge:
  - set_i = RSV_EN && RSV_ADDR==i
  - clr_i = RD_LE && RD==i
  - busy_i <= set_i ? 1 : (clr_i ? 0 : busy_i)
  - Set wins over clear on the same edge: the new reservation belongs to the younger instruction.
  - Reserving an already-busy register keeps it busy (no count; single outstanding writer per register).
  - A write to a non-busy register is legal and leaves it 0.
- RS1_BUSY / RS2_BUSY: registered with the same write/read ordering as data.
  - They reflect busy after this edge's set/clear when WRITE_FIRST=1, and before it when WRITE_FIRST=0.
- BUSY_VEC is the scoreboard register itself, valid the cycle after the edge that updated it.
- No out-of-range addresses exist (DEPTH = 2**ADDR_W); no default/X outputs.
- DATA_IN is stored unmodified; no arithmetic; all widths exact, no truncation.

Test Plan:
- Reset/async: drive RESET_N low between clock edges after writing R3=16'h1234 → RS1_DATA, BUSY_VEC and reg[3] read 0 immediately, without a clock edge.
- Write then read: write R5=16'hBEEF at edge 1; RS1=5 at edge 2 → RS1_DATA=16'hBEEF after edge 2; RS2=5 simultaneously → RS2_DATA=16'hBEEF.
- Same-edge bypass: R2 holds 16'h0001; at one edge RD_LE=1, RD=2, DATA_IN=16'h00FF, RS1=2 → RS1_DATA=16'h00FF with WRITE_FIRST=1, 16'h0001 with WRITE_FIRST=0.
- Scoreboard lifecycle: RSV_EN, RSV_ADDR=4 → BUSY_VEC=8'h10 next cycle, RS1=4 gives RS1_BUSY=1; write RD=4 → BUSY_VEC=8'h00.
- Set/clear collision: R6 busy; same edge RD_LE=1, RD=6 and RSV_EN=1, RSV_ADDR=6 → BUSY_VEC[6] stays 1 and reg[6]=DATA_IN.
- Parameter sweep: DATA_W=32, ADDR_W=4 → write 32'hDEADBEEF to R15 and read it back on all three ports; BUSY_VEC is 16 bits wide.
